decode_cycle: RTL
=================

DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have no parameters; RV32I subset, 32 registers x 32 bits, fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 InstrD  input  32  instruction from fetch stage.
REQ-005 PCD  input  32  PC of InstrD.
REQ-006 PCPlus4D  input  32  PCD+4.
REQ-007 RegWriteW  input  1  writeback enable from WB stage.
REQ-008 RDW  input  5  writeback destination register.
REQ-009 ResultW  input  32  writeback data.
REQ-010 FlushE  input  1  replace the next E-stage contents with a bubble.
REQ-011 RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE  output  1 each  registered control.
REQ-012 ALUControlE  output  3  registered ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 RD1E, RD2E  output  32  registered register-file read data.
REQ-014 ImmExtE  output  32  registered sign-extended immediate.
REQ-015 RS1E, RS2E, RDE  output  5  registered InstrD[19:15], [24:20], [11:7].
REQ-016 PCE, PCPlus4E  output  32  registered PCD, PCPlus4D.

Function
REQ-017 Decode: combinational from InstrD; ID/EX register: all E outputs, 1-cycle latency, D inputs at edge N appear on E outputs after edge N.
REQ-018 Opcode 0000011 (lw): RegWrite=1, ALUSrc=1, ResultSrc=1, MemWrite=0, Branch=0, ALU add, I-immediate.
REQ-019 Opcode 0100011 (sw): MemWrite=1, ALUSrc=1, RegWrite=0, ALU add, S-immediate.
REQ-020 Opcode 0110011 (R-type): RegWrite=1, ALUSrc=0; ALU by funct3/funct7[5]: 000/0 add, 000/1 sub, 111 and, 110 or, 010 slt.
REQ-021 Opcode 0010011 (I-ALU): RegWrite=1, ALUSrc=1, I-immediate; funct3 decoded as in REQ-020, except 000 is always add.
REQ-022 Opcode 1100011 (beq): Branch=1, ALU sub, B-immediate, RegWrite=0.
REQ-023 Any other opcode or unlisted funct3: all control 0, ALUControl 000, ImmExt 0 (bubble).
REQ-024 I-imm = sext(InstrD[31:20]); S-imm = sext({[31:25],[11:7]}); B-imm = sext({[31],[7],[30:25],[11:8],0}); extension from bit 31.
REQ-025 Register file: 32x32; reads combinational; x0 always reads 0.
REQ-026 Register file write on rising edge when RegWriteW=1 and RDW!=0; RDW=0 writes are dropped.
REQ-027 Same-cycle bypass: if RegWriteW=1, RDW!=0 and RDW equals rs1/rs2, the corresponding read returns ResultW.
REQ-028 FlushE=1 at edge: all E outputs load 0; register-file write in that cycle still occurs.

Reset
REQ-029 rst=1 at edge: all E outputs 0 and all 32 registers cleared to 0.
REQ-030 rst has priority over FlushE and over RegWriteW; a write presented during reset is discarded.
REQ-031 First valid E output appears on the edge after the first edge with rst=0.

Verification
REQ-032 rst=1 for 2 cycles, random InstrD -> every E output 0; then reading x1..x31 returns 0.
REQ-033 Write x5=0x000000AA (RegWriteW=1, RDW=5); next cycle InstrD=0x00528333 -> RD1E=RD2E=0x000000AA, RS1E=RS2E=5, RDE=6, RegWriteE=1, ALUSrcE=0, ALUControlE=000.
REQ-034 InstrD=0xFFC12083 (lw x1,-4(x2)) -> ImmExtE=0xFFFFFFFC, ALUSrcE=1, ResultSrcE=1, RegWriteE=1, MemWriteE=0, RDE=1.
REQ-035 RegWriteW=1, RDW=0, ResultW=0xDEADBEEF; then read x0 -> RD1E=0. RegWriteW=1, RDW=7, ResultW=0x00001234 in the same cycle as an InstrD reading rs1=7 -> RD1E=0x00001234.
REQ-036 FlushE=1 with lw at InstrD -> next cycle all E outputs 0. rst=1 and FlushE=1 together -> all 0. Opcode 0x7F -> all control 0.

Source files
------------

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I-subset decode stage: decoder, 32x32 register file with write bypass, ID/EX register
module decode_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  RS1E,
  output logic [4:0]  RS2E,
  output logic [4:0]  RDE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic [31:0] rf_q [32];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2;
  logic        alu_ok;
  logic [2:0]  alu_f3;
  logic        reg_write_d, alu_src_d, mem_write_d, result_src_d, branch_d;
  logic [2:0]  alu_control_d;
  logic [31:0] imm_ext_d, rd1_d, rd2_d;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign rs1    = InstrD[19:15];
  assign rs2    = InstrD[24:20];

  // funct3 -> ALU op shared by R-type and I-ALU; subtract only applied for R-type
  always_comb begin
    alu_ok = 1'b1;
    alu_f3 = 3'b000;
    case (funct3)
      3'b000:  alu_f3 = 3'b000;
      3'b111:  alu_f3 = 3'b010;
      3'b110:  alu_f3 = 3'b011;
      3'b010:  alu_f3 = 3'b101;
      default: alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    reg_write_d   = 1'b0;
    alu_src_d     = 1'b0;
    mem_write_d   = 1'b0;
    result_src_d  = 1'b0;
    branch_d      = 1'b0;
    alu_control_d = 3'b000;
    imm_ext_d     = 32'h0;
    case (opcode)
      7'b0000011: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = 1'b1;
        imm_ext_d    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      7'b0100011: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_ext_d   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      7'b0110011: begin
        if (alu_ok) begin
          reg_write_d   = 1'b1;
          alu_control_d = (funct3 == 3'b000 && InstrD[30]) ? 3'b001 : alu_f3;
        end
      end
      7'b0010011: begin
        if (alu_ok) begin
          reg_write_d   = 1'b1;
          alu_src_d     = 1'b1;
          alu_control_d = alu_f3;
          imm_ext_d     = {{20{InstrD[31]}}, InstrD[31:20]};
        end
      end
      7'b1100011: begin
        branch_d      = 1'b1;
        alu_control_d = 3'b001;
        imm_ext_d     = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // A write landing this cycle is forwarded so the consumer never sees stale data
  always_comb begin
    rd1_d = rf_q[rs1];
    rd2_d = rf_q[rs2];
    if (RegWriteW && RDW != 5'd0 && RDW == rs1) rd1_d = ResultW;
    if (RegWriteW && RDW != 5'd0 && RDW == rs2) rd2_d = ResultW;
    if (rs1 == 5'd0) rd1_d = 32'h0;
    if (rs2 == 5'd0) rd2_d = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else if (RegWriteW && RDW != 5'd0) begin
      rf_q[RDW] <= ResultW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      RD1E        <= 32'h0;
      RD2E        <= 32'h0;
      ImmExtE     <= 32'h0;
      RS1E        <= 5'd0;
      RS2E        <= 5'd0;
      RDE         <= 5'd0;
      PCE         <= 32'h0;
      PCPlus4E    <= 32'h0;
    end else begin
      RegWriteE   <= reg_write_d;
      ALUSrcE     <= alu_src_d;
      MemWriteE   <= mem_write_d;
      ResultSrcE  <= result_src_d;
      BranchE     <= branch_d;
      ALUControlE <= alu_control_d;
      RD1E        <= rd1_d;
      RD2E        <= rd2_d;
      ImmExtE     <= imm_ext_d;
      RS1E        <= rs1;
      RS2E        <= rs2;
      RDE         <= InstrD[11:7];
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule
